// File: rtl/r_bram_addr.sv
// r_bram_addr
// Read-side address generator for the interleaved row-buffer BRAM. Pixel x of
// buffer row r is stored at r + x*RB_COUNT. Once KERNEL_ROWS complete lines are
// buffered, every column is swept. Each column issues KERNEL_ROWS vertical tap
// reads, starting at top_row. Each finished output line frees one buffer row.
//
// State table:
//   state       | meaning
//   ------------+---------------------------------------------------------
//   S_IDLE      | not armed; waiting for a frame_filled rising edge
//   S_WAIT_ROWS | armed; waiting until KERNEL_ROWS rows are available
//   S_READ      | sweeping columns, one tap read per accepted cycle
//   S_LINE_END  | one-cycle line_done, advance top_row, release one row
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous active-low reset
//   enable        global run; low freezes the FSM (rows_avail still counts)
//   frame_filled  a rising edge arms the reader (only while idle)
//   row_written   one-cycle pulse per complete line written
//   out_ready     downstream can accept a tap this cycle
//   read_addr     BRAM read address (registered)
//   read_en       BRAM read strobe (registered)
//   tap_idx       tap number belonging to read_addr
//   data_valid    read_en delayed by BRAM_LATENCY
//   data_tap_last with data_valid: the last tap of a column
//   line_done     one-cycle pulse after the last read of a line
//   rows_avail    filled, unconsumed buffer rows
//   overflow      sticky: a row was written while all rows were full
module r_bram_addr #(
    parameter int RB_COUNT     = 8,
    parameter int IMAGE_WIDTH  = 256,
    parameter int MEM_DEPTH    = RB_COUNT * IMAGE_WIDTH,
    parameter int KERNEL_ROWS  = 3,
    parameter int BRAM_LATENCY = 1,
    localparam int AW = $clog2(MEM_DEPTH),
    localparam int TW = $clog2(KERNEL_ROWS),
    localparam int CW = $clog2(RB_COUNT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          frame_filled,
    input  logic          row_written,
    input  logic          out_ready,
    output logic [AW-1:0] read_addr,
    output logic          read_en,
    output logic [TW-1:0] tap_idx,
    output logic          data_valid,
    output logic          data_tap_last,
    output logic          line_done,
    output logic [CW-1:0] rows_avail,
    output logic          overflow
);

    localparam int RBW  = $clog2(RB_COUNT);
    localparam int COLW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_ROWS = 2'd1,
        S_READ      = 2'd2,
        S_LINE_END  = 2'd3
    } state_t;

    state_t                  state;
    logic                    ff_prev;
    logic [RBW-1:0]          top_row;
    logic [COLW-1:0]         col;
    logic [TW-1:0]           tap;
    logic [BRAM_LATENCY-1:0] vld_pipe;
    logic [BRAM_LATENCY-1:0] last_pipe;

    logic          frame_edge;
    logic          last_read;
    logic          rows_dec;
    logic [AW-1:0] row_sel;
    logic [AW-1:0] issue_addr;

    always_comb begin
        frame_edge = frame_filled && !ff_prev;
        last_read  = (col == COLW'(IMAGE_WIDTH - 1)) && (tap == TW'(KERNEL_ROWS - 1));
        rows_dec   = (state == S_LINE_END) && enable;
        // RB_COUNT is a power of two, so the row wrap is a mask.
        row_sel    = (AW'(top_row) + AW'(tap)) & AW'(RB_COUNT - 1);
        issue_addr = row_sel + AW'(col) * AW'(RB_COUNT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            ff_prev   <= 1'b0;
            top_row   <= '0;
            col       <= '0;
            tap       <= '0;
            read_addr <= '0;
            read_en   <= 1'b0;
            tap_idx   <= '0;
            line_done <= 1'b0;
        end else begin
            ff_prev   <= frame_filled;
            read_en   <= 1'b0;
            line_done <= 1'b0;
            if (enable) begin
                case (state)
                    S_IDLE: begin
                        if (frame_edge) state <= S_WAIT_ROWS;
                    end
                    S_WAIT_ROWS: begin
                        if (rows_avail >= CW'(KERNEL_ROWS)) begin
                            col   <= '0;
                            tap   <= '0;
                            state <= S_READ;
                        end
                    end
                    S_READ: begin
                        // Address, tap and column only move on an accepted read,
                        // so a stall neither skips nor repeats a tap.
                        if (out_ready) begin
                            read_en   <= 1'b1;
                            read_addr <= issue_addr;
                            tap_idx   <= tap;
                            if (tap == TW'(KERNEL_ROWS - 1)) begin
                                tap <= '0;
                                col <= col + 1'b1;
                            end else begin
                                tap <= tap + 1'b1;
                            end
                            if (last_read) state <= S_LINE_END;
                        end
                    end
                    S_LINE_END: begin
                        line_done <= 1'b1;
                        top_row   <= top_row + 1'b1;
                        state     <= S_WAIT_ROWS;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Row accounting runs in every state; a write and a release in the same
    // cycle cancel out, and a write into a full buffer only raises overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rows_avail <= '0;
            overflow   <= 1'b0;
        end else begin
            if (row_written && !rows_dec) begin
                if (rows_avail == CW'(RB_COUNT)) overflow <= 1'b1;
                else                              rows_avail <= rows_avail + 1'b1;
            end else if (rows_dec && !row_written && rows_avail != '0) begin
                rows_avail <= rows_avail - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            vld_pipe[0]  <= read_en;
            last_pipe[0] <= read_en && (tap_idx == TW'(KERNEL_ROWS - 1));
            for (int i = 1; i < BRAM_LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
        end
    end

    assign data_valid    = vld_pipe[BRAM_LATENCY-1];
    assign data_tap_last = last_pipe[BRAM_LATENCY-1];

endmodule

// File: tb/tb_r_bram_addr.sv
// tb_r_bram_addr
// Self-checking bench for r_bram_addr. Two instances share stimulus: one with
// BRAM_LATENCY=1 and one with BRAM_LATENCY=2. Both are compared every cycle
// against a line/position-based reference model. The model also tracks
// rows_avail, overflow and the delayed data_valid history.
module tb_r_bram_addr;

    localparam int RB = 8;
    localparam int W  = 256;
    localparam int K  = 3;

    localparam int P_IDLE = 0;
    localparam int P_WAIT = 1;
    localparam int P_READ = 2;
    localparam int P_LEND = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;
    logic frame_filled = 1'b0;
    logic row_written = 1'b0;
    logic out_ready = 1'b0;

    logic [10:0] rd_addr1, rd_addr2;
    logic        rd_en1, rd_en2;
    logic [1:0]  tap1, tap2;
    logic        dv1, dv2, dl1, dl2, ld1, ld2, ovf1, ovf2;
    logic [3:0]  rows1, rows2;

    int n_checks = 0;
    int n_err    = 0;

    // reference model state
    int m_phase, m_ffp, m_rows, m_ovf, m_line, m_pos;
    int e_en, e_addr, e_tap, e_ld;
    int h1_en, h1_last, h2_en, h2_last;

    r_bram_addr #(.RB_COUNT(RB), .IMAGE_WIDTH(W), .KERNEL_ROWS(K), .BRAM_LATENCY(1)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .frame_filled(frame_filled),
        .row_written(row_written), .out_ready(out_ready),
        .read_addr(rd_addr1), .read_en(rd_en1), .tap_idx(tap1),
        .data_valid(dv1), .data_tap_last(dl1), .line_done(ld1),
        .rows_avail(rows1), .overflow(ovf1)
    );

    r_bram_addr #(.RB_COUNT(RB), .IMAGE_WIDTH(W), .KERNEL_ROWS(K), .BRAM_LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst), .enable(enable), .frame_filled(frame_filled),
        .row_written(row_written), .out_ready(out_ready),
        .read_addr(rd_addr2), .read_en(rd_en2), .tap_idx(tap2),
        .data_valid(dv2), .data_tap_last(dl2), .line_done(ld2),
        .rows_avail(rows2), .overflow(ovf2)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_ffp = 0; m_rows = 0; m_ovf = 0; m_line = 0; m_pos = 0;
        e_en = 0; e_addr = 0; e_tap = 0; e_ld = 0;
        h1_en = 0; h1_last = 0; h2_en = 0; h2_last = 0;
    endtask

    // One clock of the reference: the address follows from the line count and
    // the position inside the line, not from separate tap/column counters.
    task automatic model_step();
        int dec;
        h2_en = h1_en; h2_last = h1_last;
        h1_en = e_en;  h1_last = (e_en != 0 && e_tap == K - 1) ? 1 : 0;
        e_en = 0; e_ld = 0; dec = 0;
        if (enable) begin
            case (m_phase)
                P_IDLE: if (frame_filled && m_ffp == 0) m_phase = P_WAIT;
                P_WAIT: if (m_rows >= K) begin m_phase = P_READ; m_pos = 0; end
                P_READ: if (out_ready) begin
                    e_en   = 1;
                    e_tap  = m_pos % K;
                    e_addr = ((m_line + e_tap) % RB) + (m_pos / K) * RB;
                    m_pos++;
                    if (m_pos == W * K) m_phase = P_LEND;
                end
                default: begin
                    e_ld = 1; m_line++; dec = 1; m_phase = P_WAIT;
                end
            endcase
        end
        if (row_written && dec == 0) begin
            if (m_rows == RB) m_ovf = 1;
            else m_rows++;
        end else if (dec != 0 && !row_written && m_rows > 0) begin
            m_rows--;
        end
        m_ffp = frame_filled ? 1 : 0;
    endtask

    task automatic check_all();
        chk("read_en", rd_en1, e_en);
        chk("read_addr", rd_addr1, e_addr);
        chk("tap_idx", tap1, e_tap);
        chk("line_done", ld1, e_ld);
        chk("rows_avail", rows1, m_rows);
        chk("overflow", ovf1, m_ovf);
        chk("data_valid", dv1, h1_en);
        chk("data_tap_last", dl1, h1_last);
        chk("lat2_read_en", rd_en2, e_en);
        chk("lat2_read_addr", rd_addr2, e_addr);
        chk("lat2_data_valid", dv2, h2_en);
        chk("lat2_data_tap_last", dl2, h2_last);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic pulse_row();
        row_written = 1'b1; step(); row_written = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_filled = 1'b1; step(); frame_filled = 1'b0; step();
    endtask

    task automatic next_read(input int exp_addr, input string nm);
        int n;
        n = 0;
        do begin step(); n++; end while (!rd_en1 && n < 2000);
        chk({nm, "_en"}, rd_en1, 1);
        chk(nm, rd_addr1, exp_addr);
    endtask

    task automatic wait_read(input int target, input int budget);
        int n;
        n = 0;
        while (!(rd_en1 && rd_addr1 == target) && n < budget) begin step(); n++; end
        chk("wait_read_found", (rd_en1 && rd_addr1 == target), 1);
    endtask

    task automatic finish_line(input int top, input bit coincide, input int rows_after);
        wait_read(2040 + (top + 2) % RB, 4000);
        row_written = coincide;
        step();
        row_written = 1'b0;
        chk("line_end_pulse", ld1, 1);
        chk("rows_after_line", rows1, rows_after);
    endtask

    typedef struct {
        bit rw;
        int rows;
        bit ovf;
    } vec_t;

    vec_t tbl[10];

    initial begin
        for (int i = 0; i < 9; i++) begin
            tbl[i].rw   = 1'b1;
            tbl[i].rows = (i < 8) ? i + 1 : 8;
            tbl[i].ovf  = (i == 8);
        end
        tbl[9].rw = 1'b0; tbl[9].rows = 8; tbl[9].ovf = 1'b1;

        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b1;
        enable = 1'b1;

        // rows_avail counting and overflow while idle
        for (int i = 0; i < 10; i++) begin
            row_written = tbl[i].rw;
            step();
            chk("tbl_rows_avail", rows1, tbl[i].rows);
            chk("tbl_overflow", ovf1, tbl[i].ovf);
        end
        row_written = 1'b0;
        do_reset();

        // line 1: top_row 0, with a 5-cycle stall at col 17 tap 1
        out_ready = 1'b1;
        pulse_frame();
        repeat (3) pulse_row();
        next_read(0, "l1_c0_t0");
        next_read(1, "l1_c0_t1");
        next_read(2, "l1_c0_t2");
        next_read(8, "l1_c1_t0");
        next_read(9, "l1_c1_t1");
        next_read(10, "l1_c1_t2");
        wait_read(137, 500);
        out_ready = 1'b0;
        repeat (5) begin
            step();
            chk("stall_read_en", rd_en1, 0);
            chk("stall_addr_hold", rd_addr1, 137);
        end
        out_ready = 1'b1;
        step();
        chk("resume_read_en", rd_en1, 1);
        chk("resume_addr", rd_addr1, 138);
        finish_line(0, 1'b0, 2);
        repeat (10) step();
        chk("waiting_no_read", rd_en1, 0);

        // line 2 (top_row 1); its end coincides with a row write
        pulse_row();
        next_read(1, "l2_c0_t0");
        next_read(2, "l2_c0_t1");
        next_read(3, "l2_c0_t2");
        finish_line(1, 1'b1, 3);
        for (int t = 2; t < 6; t++) finish_line(t, 1'b1, 3);

        // top_row 6: taps wrap round the buffer
        next_read(6, "l7_c0_t0");
        next_read(7, "l7_c0_t1");
        next_read(0, "l7_c0_t2");

        // asynchronous reset in the middle of a sweep
        wait_read(6 + 100 * RB, 1000);
        do_reset();
        chk("rst_read_en", rd_en1, 0);
        chk("rst_data_valid", dv2, 0);
        chk("rst_rows_avail", rows1, 0);
        repeat (3) pulse_row();
        repeat (10) step();
        chk("not_rearmed", rd_en1, 0);
        pulse_frame();
        next_read(0, "rearm_c0_t0");

        // randomized run
        for (int c = 0; c < 4000; c++) begin
            enable       = ($urandom_range(0, 7) != 0);
            out_ready    = ($urandom_range(0, 3) != 0);
            row_written  = ($urandom_range(0, 299) == 0);
            frame_filled = ($urandom_range(0, 49) == 0);
            step();
        end
        row_written = 1'b0;
        frame_filled = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
